// File: rtl/cacheline_arbiter_if.sv
// Bundle of the I-cache, D-cache and burst-memory signals around cacheline_arbiter.
// Latency: none (wires only).
// Backpressure: none of its own; the memory side paces beats through pmem_resp.
// Modports:
//    slave  - arbiter view: cache requests and pmem_resp/pmem_rdata in; lines, resp pulses and burst controls out
//    master - environment view (the caches plus the memory), the mirror of slave
interface cacheline_arbiter_if #(
   parameter int BEAT_W    = 64,
   parameter int BURST_LEN = 4,
   parameter int ADDR_W    = 32
);
   localparam int LINE_W = BEAT_W * BURST_LEN;

   logic              icache_read;
   logic [ADDR_W-1:0] icache_address;
   logic [LINE_W-1:0] icache_rdata;
   logic              icache_resp;

   logic              dcache_read;
   logic              dcache_write;
   logic [ADDR_W-1:0] dcache_address;
   logic [LINE_W-1:0] dcache_wdata;
   logic [LINE_W-1:0] dcache_rdata;
   logic              dcache_resp;

   logic [ADDR_W-1:0] pmem_address;
   logic              pmem_read;
   logic              pmem_write;
   logic [BEAT_W-1:0] pmem_wdata;
   logic [BEAT_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  icache_read, icache_address, dcache_read, dcache_write,
             dcache_address, dcache_wdata, pmem_rdata, pmem_resp,
      output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
             pmem_address, pmem_read, pmem_write, pmem_wdata
   );

   modport master (
      output icache_read, icache_address, dcache_read, dcache_write,
             dcache_address, dcache_wdata, pmem_rdata, pmem_resp,
      input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
             pmem_address, pmem_read, pmem_write, pmem_wdata
   );
endinterface

// File: rtl/cacheline_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one burst memory port (D-side has fixed priority).
// Latency: 1 cycle to grant, 1 cycle per accepted beat, resp 1 cycle after the last beat.
// Backpressure: beats advance only on pmem_resp; one transaction in flight, other requests wait in IDLE.
// Ports:
//    clk, rst - rising-edge clock, asynchronous active-high reset
//    bus      - cacheline_arbiter_if.slave: icache_* / dcache_* client sides and pmem_* burst port
module cacheline_arbiter #(
   parameter int BEAT_W    = 64,
   parameter int BURST_LEN = 4,
   parameter int ADDR_W    = 32
) (
   input logic                clk,
   input logic                rst,
   cacheline_arbiter_if.slave bus
);
   localparam int LINE_W = BEAT_W * BURST_LEN;
   localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_LEN - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

   typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, I_DONE, D_DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [LINE_W-1:0] line_buf;
   logic [LINE_W-1:0] buf_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic              rd_q;
   logic              wr_q;
   logic              i_resp_q;
   logic              d_resp_q;
   logic [LINE_W-1:0] i_rdata_q;
   logic [LINE_W-1:0] d_rdata_q;
   logic              last_beat;

   // Line buffer with the current beat merged in, so the final beat lands in
   // the client's rdata register on the same edge that enters *_DONE.
   always_comb begin
      buf_nxt = line_buf;
      buf_nxt[cnt*BEAT_W +: BEAT_W] = bus.pmem_rdata;
   end

   assign last_beat = bus.pmem_resp && (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         line_buf  <= '0;
         addr_q    <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         i_resp_q  <= 1'b0;
         d_resp_q  <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.dcache_write) begin
                  state  <= D_WR;
                  addr_q <= bus.dcache_address;
                  wr_q   <= 1'b1;
               end else if (bus.dcache_read) begin
                  state  <= D_RD;
                  addr_q <= bus.dcache_address;
                  rd_q   <= 1'b1;
               end else if (bus.icache_read) begin
                  state  <= I_RD;
                  addr_q <= bus.icache_address;
                  rd_q   <= 1'b1;
               end
            end
            I_RD, D_RD: begin
               if (bus.pmem_resp) begin
                  line_buf <= buf_nxt;
                  if (last_beat) begin
                     cnt  <= '0;
                     rd_q <= 1'b0;
                     if (state == I_RD) begin
                        state     <= I_DONE;
                        i_resp_q  <= 1'b1;
                        i_rdata_q <= buf_nxt;
                     end else begin
                        state     <= D_DONE;
                        d_resp_q  <= 1'b1;
                        d_rdata_q <= buf_nxt;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            D_WR: begin
               if (bus.pmem_resp) begin
                  if (last_beat) begin
                     cnt      <= '0;
                     wr_q     <= 1'b0;
                     state    <= D_DONE;
                     d_resp_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            I_DONE: begin
               i_resp_q <= 1'b0;
               state    <= IDLE;
            end
            D_DONE: begin
               d_resp_q <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Full address is latched; the offset bits are masked here to give a line-aligned burst.
   assign bus.pmem_address = addr_q & LINE_MASK;
   assign bus.pmem_read    = rd_q;
   assign bus.pmem_write   = wr_q;
   // Beat select follows cnt; gated so the port reads zero outside a write burst.
   assign bus.pmem_wdata   = wr_q ? bus.dcache_wdata[cnt*BEAT_W +: BEAT_W] : '0;
   assign bus.icache_resp  = i_resp_q;
   assign bus.icache_rdata = i_rdata_q;
   assign bus.dcache_resp  = d_resp_q;
   assign bus.dcache_rdata = d_rdata_q;
endmodule
